// File: rtl/wired_arf_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// wired_arf_scoreboard_pkg
//   Common backend typedefs shared by the rename/dispatch/commit blocks.
//   arch_rid_t : architectural register index
//   rob_tag_t  : reorder-buffer tag of an in-flight producer
//   is_pow2()  : elaboration-time helper for storage geometry checks
// -----------------------------------------------------------------------------
package wired_arf_scoreboard_pkg;

  localparam int ARF_DEPTH     = 32;
  localparam int ARF_AW        = $clog2(ARF_DEPTH);
  localparam int ROB_TAG_WIDTH = 6;

  typedef logic [ARF_AW-1:0]        arch_rid_t;
  typedef logic [ROB_TAG_WIDTH-1:0] rob_tag_t;

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/wired_arf_prio_sel.sv
// -----------------------------------------------------------------------------
// wired_arf_prio_sel
//   Per-register priority select over N request ports. For every register r,
//   hit_o[r] is set when any valid port addresses r, and payload_o[r] carries
//   the payload of the highest-index (youngest) port that hit.
//   Ports:
//     valid_i   [N]        request valid per port
//     addr_i    [N*AW]     register address per port
//     payload_i [N*PW]     payload per port
//     hit_o     [DEPTH]    some port targets this register
//     payload_o [DEPTH*PW] winning payload (0 when no hit)
// -----------------------------------------------------------------------------
module wired_arf_prio_sel #(
  parameter int N     = 2,
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int PW    = 32
) (
  input  logic [N-1:0]              valid_i,
  input  logic [N*AW-1:0]           addr_i,
  input  logic [N*PW-1:0]           payload_i,
  output logic [DEPTH-1:0]          hit_o,
  output logic [DEPTH-1:0][PW-1:0]  payload_o
);

  always_comb begin
    // NOTE: every output gets a default before the loops so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    hit_o     = '0;
    payload_o = '0;
    for (int r = 0; r < DEPTH; r++) begin
      for (int i = 0; i < N; i++) begin
        if (valid_i[i] && (addr_i[i*AW +: AW] == AW'(r))) begin
          // NOTE: blocking assignments in combinational logic; a later (higher
          // index) port overwrites an earlier one, which is the priority rule.
          hit_o[r]     = 1'b1;
          payload_o[r] = payload_i[i*PW +: PW];
        end
      end
    end
  end

endmodule

// File: rtl/wired_arf_scoreboard.sv
// -----------------------------------------------------------------------------
// wired_arf_scoreboard
//   Architectural register file with per-register busy/tag scoreboard used by
//   the rename stage. Reads are registered and see the post-update state of the
//   same edge (write-first bypass).
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     raddr_i/rdata_o/rbusy_o/rtag_o   R read ports, 1-cycle latency
//     alloc_valid_i/alloc_addr_i/alloc_tag_i  S dispatch allocate ports
//     we_i/waddr_i/wdata_i/wtag_i      W commit write ports
//     flush_i                  clear every busy bit (pipeline redirect)
// -----------------------------------------------------------------------------
module wired_arf_scoreboard
  import wired_arf_scoreboard_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = ARF_DEPTH,
  parameter int R_PORT_COUNT = 4,
  parameter int W_PORT_COUNT = 2,
  parameter int S_PORT_COUNT = 2,
  parameter int TAG_WIDTH    = ROB_TAG_WIDTH,
  parameter int ZERO_REG     = 1,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [R_PORT_COUNT*AW-1:0]         raddr_i,
  output logic [R_PORT_COUNT*DATA_WIDTH-1:0] rdata_o,
  output logic [R_PORT_COUNT-1:0]            rbusy_o,
  output logic [R_PORT_COUNT*TAG_WIDTH-1:0]  rtag_o,
  input  logic [S_PORT_COUNT-1:0]            alloc_valid_i,
  input  logic [S_PORT_COUNT*AW-1:0]         alloc_addr_i,
  input  logic [S_PORT_COUNT*TAG_WIDTH-1:0]  alloc_tag_i,
  input  logic [W_PORT_COUNT-1:0]            we_i,
  input  logic [W_PORT_COUNT*AW-1:0]         waddr_i,
  input  logic [W_PORT_COUNT*DATA_WIDTH-1:0] wdata_i,
  input  logic [W_PORT_COUNT*TAG_WIDTH-1:0]  wtag_i,
  input  logic                               flush_i
);

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("wired_arf_scoreboard: DEPTH must be a power of two >= 2");
  end

  logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q, data_nxt;
  logic [DEPTH-1:0][TAG_WIDTH-1:0]  tag_q, tag_nxt;
  logic [DEPTH-1:0]                 busy_q, busy_nxt;

  logic [DEPTH-1:0]                 wr_hit, clr_hit, alloc_hit;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] wr_data;
  logic [DEPTH-1:0][TAG_WIDTH-1:0]  clr_tag, alloc_tag;

  // A redirect kills everything younger than commit, including this cycle's
  // dispatch, so allocations are squashed before they reach the selector.
  logic [S_PORT_COUNT-1:0] alloc_live;
  assign alloc_live = alloc_valid_i & {S_PORT_COUNT{~flush_i}};

  wired_arf_prio_sel #(
    .N(W_PORT_COUNT), .DEPTH(DEPTH), .AW(AW), .PW(DATA_WIDTH)
  ) u_wr_data_sel (
    .valid_i(we_i), .addr_i(waddr_i), .payload_i(wdata_i),
    .hit_o(wr_hit), .payload_o(wr_data)
  );

  wired_arf_prio_sel #(
    .N(W_PORT_COUNT), .DEPTH(DEPTH), .AW(AW), .PW(TAG_WIDTH)
  ) u_wr_tag_sel (
    .valid_i(we_i), .addr_i(waddr_i), .payload_i(wtag_i),
    .hit_o(clr_hit), .payload_o(clr_tag)
  );

  wired_arf_prio_sel #(
    .N(S_PORT_COUNT), .DEPTH(DEPTH), .AW(AW), .PW(TAG_WIDTH)
  ) u_alloc_sel (
    .valid_i(alloc_live), .addr_i(alloc_addr_i), .payload_i(alloc_tag_i),
    .hit_o(alloc_hit), .payload_o(alloc_tag)
  );

  // Next-state per register. Precedence for busy: flush > alloc > tag-matched
  // commit clear > hold. Data follows commits unconditionally (in-order commit).
  always_comb begin
    data_nxt = data_q;
    tag_nxt  = tag_q;
    busy_nxt = busy_q;
    for (int r = 0; r < DEPTH; r++) begin
      if (wr_hit[r]) data_nxt[r] = wr_data[r];

      if (alloc_hit[r]) tag_nxt[r] = alloc_tag[r];

      if (flush_i)
        busy_nxt[r] = 1'b0;
      else if (alloc_hit[r])
        busy_nxt[r] = 1'b1;
      else if (clr_hit[r] && busy_q[r] && (tag_q[r] == clr_tag[r]))
        busy_nxt[r] = 1'b0;

      if ((ZERO_REG != 0) && (r == 0)) begin
        data_nxt[r] = '0;
        tag_nxt[r]  = '0;
        busy_nxt[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the storage arrays are reset here on purpose: rename relies on
      // every register reading as committed zero after reset, and the flop
      // array is small enough that this costs only reset fan-out.
      data_q  <= '0;
      tag_q   <= '0;
      busy_q  <= '0;
      rdata_o <= '0;
      rbusy_o <= '0;
      rtag_o  <= '0;
    end else begin
      // NOTE: non-blocking assignments for all state so every register samples
      // the pre-edge values regardless of statement order.
      data_q <= data_nxt;
      tag_q  <= tag_nxt;
      busy_q <= busy_nxt;
      // Reads index the next-state vectors, giving write-first behaviour.
      for (int p = 0; p < R_PORT_COUNT; p++) begin
        rdata_o[p*DATA_WIDTH +: DATA_WIDTH] <= data_nxt[raddr_i[p*AW +: AW]];
        rbusy_o[p]                          <= busy_nxt[raddr_i[p*AW +: AW]];
        rtag_o[p*TAG_WIDTH +: TAG_WIDTH]    <= tag_nxt[raddr_i[p*AW +: AW]];
      end
    end
  end

endmodule

// File: tb/tb_wired_arf_scoreboard.sv
module tb_wired_arf_scoreboard;

  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int R     = 4;
  localparam int W     = 2;
  localparam int S     = 2;
  localparam int TW    = 6;
  localparam int AW    = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [R*AW-1:0] raddr;
  logic [R*DW-1:0] rdata;
  logic [R-1:0]    rbusy;
  logic [R*TW-1:0] rtag;
  logic [S-1:0]    alloc_valid;
  logic [S*AW-1:0] alloc_addr;
  logic [S*TW-1:0] alloc_tag;
  logic [W-1:0]    we;
  logic [W*AW-1:0] waddr;
  logic [W*DW-1:0] wdata;
  logic [W*TW-1:0] wtag;
  logic            flush;

  int n_checks = 0;
  int n_fail   = 0;

  wired_arf_scoreboard #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .R_PORT_COUNT(R), .W_PORT_COUNT(W),
    .S_PORT_COUNT(S), .TAG_WIDTH(TW), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst(rst),
    .raddr_i(raddr), .rdata_o(rdata), .rbusy_o(rbusy), .rtag_o(rtag),
    .alloc_valid_i(alloc_valid), .alloc_addr_i(alloc_addr), .alloc_tag_i(alloc_tag),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .wtag_i(wtag),
    .flush_i(flush)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rd(input int p);
    return rdata[p*DW +: DW];
  endfunction

  function automatic logic [TW-1:0] rt(input int p);
    return rtag[p*TW +: TW];
  endfunction

  task automatic clear_inputs();
    raddr       = '0;
    alloc_valid = '0;
    alloc_addr  = '0;
    alloc_tag   = '0;
    we          = '0;
    waddr       = '0;
    wdata       = '0;
    wtag        = '0;
    flush       = 1'b0;
  endtask

  task automatic set_read(input int p, input int a);
    raddr[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_alloc(input int s, input int a, input logic [TW-1:0] t);
    alloc_valid[s]         = 1'b1;
    alloc_addr[s*AW +: AW] = AW'(a);
    alloc_tag[s*TW +: TW]  = t;
  endtask

  task automatic set_write(input int w, input int a, input logic [DW-1:0] d,
                           input logic [TW-1:0] t);
    we[w]             = 1'b1;
    waddr[w*AW +: AW] = AW'(a);
    wdata[w*DW +: DW] = d;
    wtag[w*TW +: TW]  = t;
  endtask

  // Advance one edge and settle away from it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    for (int p = 0; p < R; p++) set_read(p, 5);
    set_write(0, 5, 32'h0000_AAAA, 6'h01);
    set_alloc(0, 5, 6'h07);
    tick();
    n_checks++;
    if (rdata !== '0 || rbusy !== '0 || rtag !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%h busy=%b tag=%h, expected all zero",
               rdata, rbusy, rtag);
    end
    rst = 1'b0;
    clear_inputs();
    for (int p = 0; p < R; p++) set_read(p, 5);
    tick();
    for (int p = 0; p < R; p++) begin
      n_checks++;
      if (rd(p) !== 32'h0 || rbusy[p] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_r5_port%0d: got data=%h busy=%b, expected data=0 busy=0",
                 p, rd(p), rbusy[p]);
      end
    end
  endtask

  task automatic test_alloc_commit();
    clear_inputs();
    set_alloc(0, 3, 6'h11);
    set_read(0, 3);
    tick();
    n_checks++;
    if (rd(0) !== 32'h0 || rbusy[0] !== 1'b1 || rt(0) !== 6'h11) begin
      n_fail++;
      $display("FAIL alloc_r3: got data=%h busy=%b tag=%h, expected 0/1/11",
               rd(0), rbusy[0], rt(0));
    end
    clear_inputs();
    set_write(0, 3, 32'hDEAD_BEEF, 6'h11);
    set_read(0, 3);
    tick();
    n_checks++;
    if (rd(0) !== 32'hDEAD_BEEF || rbusy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL commit_r3: got data=%h busy=%b, expected deadbeef/0",
               rd(0), rbusy[0]);
    end
  endtask

  task automatic test_tag_mismatch();
    clear_inputs();
    set_alloc(1, 3, 6'h11);
    tick();
    clear_inputs();
    set_write(1, 3, 32'h1234_5678, 6'h05);
    set_read(2, 3);
    tick();
    n_checks++;
    if (rd(2) !== 32'h1234_5678 || rbusy[2] !== 1'b1 || rt(2) !== 6'h11) begin
      n_fail++;
      $display("FAIL stale_commit_r3: got data=%h busy=%b tag=%h, expected 12345678/1/11",
               rd(2), rbusy[2], rt(2));
    end
  endtask

  task automatic test_alloc_beats_clear();
    clear_inputs();
    set_alloc(0, 7, 6'h21);
    tick();
    clear_inputs();
    set_alloc(1, 7, 6'h22);
    set_write(1, 7, 32'hCAFE_0007, 6'h21);
    set_read(0, 7);
    tick();
    n_checks++;
    if (rd(0) !== 32'hCAFE_0007 || rbusy[0] !== 1'b1 || rt(0) !== 6'h22) begin
      n_fail++;
      $display("FAIL alloc_vs_clear_r7: got data=%h busy=%b tag=%h, expected cafe0007/1/22",
               rd(0), rbusy[0], rt(0));
    end
  endtask

  task automatic test_multi_port();
    clear_inputs();
    set_write(0, 9, 32'h1, 6'h00);
    set_write(1, 9, 32'h2, 6'h00);
    set_read(1, 9);
    tick();
    n_checks++;
    if (rd(1) !== 32'h2) begin
      n_fail++;
      $display("FAIL dual_write_r9: got data=%h, expected 00000002", rd(1));
    end
    clear_inputs();
    set_alloc(0, 9, 6'h03);
    set_alloc(1, 9, 6'h04);
    set_read(3, 9);
    tick();
    n_checks++;
    if (rbusy[3] !== 1'b1 || rt(3) !== 6'h04) begin
      n_fail++;
      $display("FAIL dual_alloc_r9: got busy=%b tag=%h, expected 1/04", rbusy[3], rt(3));
    end
    clear_inputs();
    set_write(0, 10, 32'h0000_000A, 6'h00);
    set_write(1, 11, 32'h0000_000B, 6'h00);
    set_read(2, 10);
    set_read(3, 11);
    tick();
    n_checks++;
    if (rd(2) !== 32'h0000_000A || rd(3) !== 32'h0000_000B) begin
      n_fail++;
      $display("FAIL split_write_r10_r11: got %h/%h, expected 0000000a/0000000b",
               rd(2), rd(3));
    end
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    set_alloc(0, 12, 6'h01);
    tick();
    clear_inputs();
    set_write(0, 12, 32'h0000_0100, 6'h01);
    set_alloc(0, 12, 6'h02);
    set_read(1, 12);
    tick();
    n_checks++;
    if (rd(1) !== 32'h0000_0100 || rbusy[1] !== 1'b1 || rt(1) !== 6'h02) begin
      n_fail++;
      $display("FAIL b2b_realloc_r12: got data=%h busy=%b tag=%h, expected 00000100/1/02",
               rd(1), rbusy[1], rt(1));
    end
    clear_inputs();
    set_write(1, 12, 32'h0000_0200, 6'h02);
    set_read(1, 12);
    tick();
    n_checks++;
    if (rd(1) !== 32'h0000_0200 || rbusy[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_commit_r12: got data=%h busy=%b, expected 00000200/0",
               rd(1), rbusy[1]);
    end
  endtask

  task automatic test_flush();
    clear_inputs();
    set_alloc(0, 6, 6'h30);
    tick();
    clear_inputs();
    flush = 1'b1;
    set_alloc(0, 4, 6'h09);
    set_write(0, 6, 32'h0000_0077, 6'h2F);
    set_read(0, 4);
    set_read(1, 6);
    set_read(2, 3);
    set_read(3, 9);
    tick();
    n_checks++;
    if (rbusy !== 4'b0000) begin
      n_fail++;
      $display("FAIL flush_busy: got busy=%b, expected 0000", rbusy);
    end
    n_checks++;
    if (rd(1) !== 32'h0000_0077 || rd(2) !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL flush_data: got r6=%h r3=%h, expected 00000077/12345678",
               rd(1), rd(2));
    end
    clear_inputs();
    set_read(0, 4);
    tick();
    n_checks++;
    if (rbusy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_r4_after: got busy=%b, expected 0", rbusy[0]);
    end
  endtask

  task automatic test_zero_reg();
    clear_inputs();
    set_write(0, 0, 32'h0000_00FF, 6'h00);
    set_alloc(1, 0, 6'h15);
    set_read(0, 0);
    tick();
    n_checks++;
    if (rd(0) !== 32'h0 || rbusy[0] !== 1'b0 || rt(0) !== 6'h00) begin
      n_fail++;
      $display("FAIL zero_reg_same: got data=%h busy=%b tag=%h, expected 0/0/0",
               rd(0), rbusy[0], rt(0));
    end
    clear_inputs();
    set_read(3, 0);
    tick();
    n_checks++;
    if (rd(3) !== 32'h0 || rbusy[3] !== 1'b0 || rt(3) !== 6'h00) begin
      n_fail++;
      $display("FAIL zero_reg_after: got data=%h busy=%b tag=%h, expected 0/0/0",
               rd(3), rbusy[3], rt(3));
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    tick();
    test_reset();
    test_alloc_commit();
    test_tag_mismatch();
    test_alloc_beats_clear();
    test_multi_port();
    test_back_to_back();
    test_flush();
    test_zero_reg();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
